rs_issue_scheduler: RTL and testbench

Issue scheduler and allocator for a bank of `NUM_RS` reservation-station entries feeding one execution unit. On the decode side it steers each new instruction into the lowest-index free entry. On the issue side it grants one ready entry per cycle in round-robin order and drives that entry's stall low so the entry releases. It then holds the granted entry index and ROB tag in an output register until the execution unit accepts it.

---
 rtl/rs_issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
// Allocation and issue control for a bank of NUM_RS reservation-station
// entries feeding a single execution unit.
//   Decode side : decodeValid_i / decodeReady_o handshake. decodeWriteEn_o is
//                 the one-hot write enable for the lowest-index free entry.
//   Issue side  : rsBusy_i / rsReady_i / rsTag_i describe each entry. One ready
//                 entry per cycle is granted in round-robin order (its
//                 rsStall_o bit drops to 0). The grant is captured in an issue
//                 register (issueValid_o, issueRs_o, issueTag_o) that is held
//                 until execReady_i accepts it.
//   Status      : issueCount_o counts accepted issues and wraps at 16 bits.
//   Control     : clk_i, async active-low reset_ni, synchronous flush_i.
module rs_issue_scheduler #(
  parameter int NUM_RS  = 4,
  parameter int ROBsize = 8,
  parameter int TW      = $clog2(ROBsize + 1),
  parameter int IW      = $clog2(NUM_RS)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 flush_i,
  input  logic                 decodeValid_i,
  output logic                 decodeReady_o,
  output logic [NUM_RS-1:0]    decodeWriteEn_o,
  input  logic [NUM_RS-1:0]    rsBusy_i,
  input  logic [NUM_RS-1:0]    rsReady_i,
  input  logic [NUM_RS*TW-1:0] rsTag_i,
  output logic [NUM_RS-1:0]    rsStall_o,
  output logic                 issueValid_o,
  output logic [IW-1:0]        issueRs_o,
  output logic [TW-1:0]        issueTag_o,
  input  logic                 execReady_i,
  output logic [15:0]          issueCount_o
);

  logic [NUM_RS-1:0] free_s;
  logic [NUM_RS-1:0] cand_s;
  logic [NUM_RS-1:0] alloc_onehot_s;
  logic              alloc_found_s;
  logic [IW-1:0]     winner_s;
  logic              win_found_s;
  logic              slot_open_s;
  logic              grant_valid_s;
  logic [NUM_RS-1:0] grant_s;
  logic [TW-1:0]     win_tag_s;
  logic [IW-1:0]     next_ptr_s;
  logic              accept_s;

  logic [IW-1:0]     rr_ptr_r;
  logic              issue_valid_r;
  logic [IW-1:0]     issue_rs_r;
  logic [TW-1:0]     issue_tag_r;
  logic [15:0]       issue_count_r;

  assign free_s      = ~rsBusy_i;
  assign cand_s      = rsReady_i & rsBusy_i;
  assign slot_open_s = ~issue_valid_r | execReady_i;
  assign accept_s    = issue_valid_r & execReady_i & ~flush_i;

  // Lowest-index free entry for allocation.
  always_comb begin
    alloc_onehot_s = '0;
    alloc_found_s  = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (!alloc_found_s && free_s[i]) begin
        alloc_onehot_s[i] = 1'b1;
        alloc_found_s     = 1'b1;
      end else begin
        alloc_found_s = alloc_found_s;
      end
    end
  end

  assign decodeReady_o = (|free_s) & ~flush_i;

  // Write enable is suppressed while reset is held so no entry is written.
  always_comb begin
    if (decodeValid_i && decodeReady_o && reset_ni) begin
      decodeWriteEn_o = alloc_onehot_s;
    end else begin
      decodeWriteEn_o = '0;
    end
  end

  // Round-robin search: first candidate at or after rr_ptr_r, wrapping at NUM_RS-1.
  always_comb begin
    winner_s    = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (!win_found_s && cand_s[(int'(rr_ptr_r) + k) % NUM_RS]) begin
        winner_s    = IW'((int'(rr_ptr_r) + k) % NUM_RS);
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Grant qualification; reset holds every stall high.
  always_comb begin
    grant_valid_s = win_found_s & slot_open_s & ~flush_i & reset_ni;
    grant_s       = '0;
    if (grant_valid_s) begin
      grant_s[winner_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign rsStall_o = ~grant_s;
  assign win_tag_s = rsTag_i[int'(winner_s)*TW +: TW];

  // Pointer moves one past the winner so the winner has lowest priority next.
  always_comb begin
    if (winner_s == IW'(NUM_RS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = winner_s + IW'(1);
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      issue_valid_r <= 1'b0;
      issue_rs_r    <= '0;
      issue_tag_r   <= '0;
      rr_ptr_r      <= '0;
    end else if (flush_i) begin
      // Flush drops the in-flight issue but keeps index/tag for visibility.
      issue_valid_r <= 1'b0;
      rr_ptr_r      <= '0;
    end else if (grant_valid_s) begin
      issue_valid_r <= 1'b1;
      issue_rs_r    <= winner_s;
      issue_tag_r   <= win_tag_s;
      rr_ptr_r      <= next_ptr_s;
    end else if (issue_valid_r && execReady_i) begin
      issue_valid_r <= 1'b0;
    end else begin
      issue_valid_r <= issue_valid_r;
    end
  end

  // Accepted-issue counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      issue_count_r <= 16'd0;
    end else if (accept_s) begin
      issue_count_r <= issue_count_r + 16'd1;
    end else begin
      issue_count_r <= issue_count_r;
    end
  end

  assign issueValid_o = issue_valid_r;
  assign issueRs_o    = issue_rs_r;
  assign issueTag_o   = issue_tag_r;
  assign issueCount_o = issue_count_r;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler (NUM_RS=4, ROBsize=8 -> TW=4).
// Expected issues are queued when the stimulus sets up a grant and are
// compared when the issue register is accepted by the execution unit.
module tb_rs_issue_scheduler;

  localparam int NUM_RS = 4;
  localparam int TW     = 4;
  localparam int IW     = 2;

  logic              clk_i;
  logic              reset_ni;
  logic              flush_i;
  logic              decodeValid_i;
  logic              decodeReady_o;
  logic [NUM_RS-1:0] decodeWriteEn_o;
  logic [NUM_RS-1:0] rsBusy_i;
  logic [NUM_RS-1:0] rsReady_i;
  logic [NUM_RS*TW-1:0] rsTag_i;
  logic [NUM_RS-1:0] rsStall_o;
  logic              issueValid_o;
  logic [IW-1:0]     issueRs_o;
  logic [TW-1:0]     issueTag_o;
  logic              execReady_i;
  logic [15:0]       issueCount_o;

  rs_issue_scheduler #(.NUM_RS(4), .ROBsize(8)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .flush_i(flush_i),
    .decodeValid_i(decodeValid_i),
    .decodeReady_o(decodeReady_o),
    .decodeWriteEn_o(decodeWriteEn_o),
    .rsBusy_i(rsBusy_i),
    .rsReady_i(rsReady_i),
    .rsTag_i(rsTag_i),
    .rsStall_o(rsStall_o),
    .issueValid_o(issueValid_o),
    .issueRs_o(issueRs_o),
    .issueTag_o(issueTag_o),
    .execReady_i(execReady_i),
    .issueCount_o(issueCount_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IW-1:0] rs;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] rs, input logic [TW-1:0] tag);
    exp_t e;
    e.rs  = rs;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Settle inputs, retire any accepted issue against the scoreboard, then clock.
  task automatic step();
    exp_t e;
    #1;
    if (sb_en) begin
      if (issueValid_o && flush_i) begin
        if (sb.size() > 0) e = sb.pop_front();
      end else if (issueValid_o && execReady_i) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_empty observed=%0h expected=none", issueRs_o);
        end else begin
          e = sb.pop_front();
          chk("sb_issue_rs", 32'(issueRs_o), 32'(e.rs));
          chk("sb_issue_tag", 32'(issueTag_o), 32'(e.tag));
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_ni      = 1'b0;
    flush_i       = 1'b0;
    decodeValid_i = 1'b0;
    rsBusy_i      = 4'b1111;
    rsReady_i     = 4'b1111;
    rsTag_i       = {4'd4, 4'd3, 4'd2, 4'd1};
    execReady_i   = 1'b1;

    // Reset state: registers clear, stall forced high, no allocation.
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_valid", 32'(issueValid_o), 32'd0);
    chk("rst_rs", 32'(issueRs_o), 32'd0);
    chk("rst_tag", 32'(issueTag_o), 32'd0);
    chk("rst_count", 32'(issueCount_o), 32'd0);
    chk("rst_stall", 32'(rsStall_o), 32'hF);
    rsBusy_i      = 4'b0000;
    decodeValid_i = 1'b1;
    #1;
    chk("rst_dec_ready", 32'(decodeReady_o), 32'd1);
    chk("rst_wen", 32'(decodeWriteEn_o), 32'd0);
    @(negedge clk_i);
    reset_ni  = 1'b1;
    rsReady_i = 4'b0000;

    // Allocation fill with busy fed back.
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fill_ready", 32'(decodeReady_o), 32'd1);
      chk("fill_wen", 32'(decodeWriteEn_o), 32'(4'b0001 << k));
      step();
      rsBusy_i = rsBusy_i | 4'(4'b0001 << k);
    end
    #1;
    chk("fill_full_ready", 32'(decodeReady_o), 32'd0);
    chk("fill_full_wen", 32'(decodeWriteEn_o), 32'd0);
    rsBusy_i = 4'b1010;
    #1;
    chk("alloc_lowest_a", 32'(decodeWriteEn_o), 32'b0001);
    rsBusy_i = 4'b1011;
    #1;
    chk("alloc_lowest_b", 32'(decodeWriteEn_o), 32'b0100);
    chk("fill_no_issue", 32'(issueValid_o), 32'd0);
    decodeValid_i = 1'b0;
    rsBusy_i      = 4'b1111;

    // Round-robin with all entries ready: 0,1,2,3,0.
    rsReady_i = 4'b1111;
    push(2'd0, 4'd1); push(2'd1, 4'd2); push(2'd2, 4'd3); push(2'd3, 4'd4); push(2'd0, 4'd1);
    #1;
    chk("rr_first_stall", 32'(rsStall_o), 32'b1110);
    step();
    chk("rr_latency_valid", 32'(issueValid_o), 32'd1);
    chk("rr_latency_rs", 32'(issueRs_o), 32'd0);
    repeat (4) step();
    rsReady_i = 4'b0000;
    step();
    chk("rr_count", 32'(issueCount_o), 32'd5);
    chk("rr_drain_valid", 32'(issueValid_o), 32'd0);

    // Backpressure: entry 2 (tag 5) held while entry 1 waits.
    rsTag_i   = {4'd4, 4'd5, 4'd2, 4'd1};
    rsReady_i = 4'b0100;
    push(2'd2, 4'd5);
    #1;
    chk("bp_grant_stall", 32'(rsStall_o), 32'b1011);
    step();
    execReady_i = 1'b0;
    rsReady_i   = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall", 32'(rsStall_o), 32'hF);
      step();
      chk("bp_valid", 32'(issueValid_o), 32'd1);
      chk("bp_rs", 32'(issueRs_o), 32'd2);
      chk("bp_tag", 32'(issueTag_o), 32'd5);
    end
    execReady_i = 1'b1;
    #1;
    chk("bp_release_stall", 32'(rsStall_o), 32'b1101);
    push(2'd1, 4'd2);
    step();
    chk("bp_next_rs", 32'(issueRs_o), 32'd1);
    rsReady_i = 4'b0000;
    step();
    chk("bp_count", 32'(issueCount_o), 32'd7);

    // Flush: pointer returns to 0 so entry 1 wins over entry 3.
    rsReady_i = 4'b0010;
    push(2'd1, 4'd2);
    step();
    chk("fl_pre_valid", 32'(issueValid_o), 32'd1);
    flush_i       = 1'b1;
    rsReady_i     = 4'b1010;
    decodeValid_i = 1'b1;
    #1;
    chk("fl_stall", 32'(rsStall_o), 32'hF);
    chk("fl_dec_ready", 32'(decodeReady_o), 32'd0);
    chk("fl_wen", 32'(decodeWriteEn_o), 32'd0);
    step();
    chk("fl_valid", 32'(issueValid_o), 32'd0);
    chk("fl_count", 32'(issueCount_o), 32'd7);
    flush_i       = 1'b0;
    decodeValid_i = 1'b0;
    #1;
    chk("fl_next_stall", 32'(rsStall_o), 32'b1101);
    push(2'd1, 4'd2);
    step();
    chk("fl_next_rs", 32'(issueRs_o), 32'd1);
    rsReady_i = 4'b0000;
    step();
    chk("fl_post_count", 32'(issueCount_o), 32'd8);

    // Asynchronous reset in mid-cycle with an issue pending.
    rsReady_i = 4'b0001;
    push(2'd0, 4'd1);
    step();
    chk("ar_pre_valid", 32'(issueValid_o), 32'd1);
    execReady_i = 1'b0;
    rsReady_i   = 4'b1111;
    #2;
    reset_ni = 1'b0;
    #1;
    chk("ar_valid", 32'(issueValid_o), 32'd0);
    chk("ar_rs", 32'(issueRs_o), 32'd0);
    chk("ar_tag", 32'(issueTag_o), 32'd0);
    chk("ar_count", 32'(issueCount_o), 32'd0);
    chk("ar_stall", 32'(rsStall_o), 32'hF);
    sb.delete();
    @(negedge clk_i);
    reset_ni    = 1'b1;
    rsReady_i   = 4'b0101;
    execReady_i = 1'b1;
    #1;
    chk("ar_first_stall", 32'(rsStall_o), 32'b1110);
    push(2'd0, 4'd1);
    step();
    chk("ar_first_rs", 32'(issueRs_o), 32'd0);
    chk("ar_first_tag", 32'(issueTag_o), 32'd1);
    rsReady_i = 4'b0000;
    step();
    chk("ar_post_count", 32'(issueCount_o), 32'd1);

    // Counter wrap: count is 1, one grant cycle then one accept per cycle.
    sb_en     = 1'b0;
    rsReady_i = 4'b1111;
    step();
    for (int k = 0; k < 65534; k++) step();
    chk("wrap_max", 32'(issueCount_o), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(issueCount_o), 32'd0);
    rsReady_i = 4'b0000;
    step();
    chk("wrap_after", 32'(issueCount_o), 32'd1);
    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
